// File: rtl/add3_seq_ctrl_pkg.sv
// add3_pkg: shared types and helpers for the sequential three-operand adder.
// Holds the controller state encoding, the inter-slice carry width and the
// beat-count helper used to size the sequencer.
package add3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Three SLICE-bit operands plus a carry of at most 2 stay below 3*2^SLICE,
  // so two carry bits between slices are always enough.
  localparam int CARRY_W = 2;

  function automatic int beats(input int w, input int slice);
    return w / slice;
  endfunction

endpackage

// File: rtl/add3_seq_ctrl_if.sv
// add3_seq_ctrl_if: operand and result handshake bundle for add3_seq_ctrl.
// The slave modport is the controller; the master modport is the operand
// source plus the result consumer.
interface add3_seq_ctrl_if #(
  parameter int W = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] c_i;
  logic         cin_i;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] sum_o;
  logic         sat_o;
  logic         busy_o;

  modport slave (
    input  in_valid, a_i, b_i, c_i, cin_i, out_ready,
    output in_ready, out_valid, sum_o, sat_o, busy_o
  );

  modport master (
    output in_valid, a_i, b_i, c_i, cin_i, out_ready,
    input  in_ready, out_valid, sum_o, sat_o, busy_o
  );

endinterface

// File: rtl/add3_seq_ctrl_slice.sv
// add3_slice: combinational SLICE-bit three-operand adder with a 2-bit
// carry-in. Two carry-save layers reduce a, b, c and the carry-in to two
// vectors, which a Kogge-Stone prefix adder then sums. The result is
// {cy, s}, exactly SLICE+2 bits wide.
module add3_slice
  import add3_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0]   a,
  input  logic [SLICE-1:0]   b,
  input  logic [SLICE-1:0]   c,
  input  logic [CARRY_W-1:0] cin,
  output logic [SLICE-1:0]   s,
  output logic [CARRY_W-1:0] cy
);

  localparam int N = SLICE + CARRY_W;

  logic [N-1:0] x, y, z, u, v;
  logic [N-2:0] m2;
  logic [N-2:0] gk, pk, gt, pt;
  logic [N-1:0] sum;

  // Carry-save reduction: a+b+c into (x,y), with cin[0] placed in the free
  // LSB of y, then fold in cin[1] (weight 2) to get the two vectors (u,v).
  always_comb begin
    x  = N'(a ^ b ^ c);
    y  = N'({(a & b) | (a & c) | (b & c), cin[0]});
    z  = N'({cin[1], 1'b0});
    u  = x ^ y ^ z;
    m2 = (x[N-2:0] & y[N-2:0]) | (x[N-2:0] & z[N-2:0]) | (y[N-2:0] & z[N-2:0]);
    v  = {m2, 1'b0};
  end

  // Kogge-Stone prefix over the generate/propagate pairs. gk[i] ends up as
  // the carry out of bit positions 0..i, i.e. the carry into bit i+1.
  always_comb begin
    gk = u[N-2:0] & v[N-2:0];
    pk = u[N-2:0] ^ v[N-2:0];
    gt = '0;
    pt = '0;
    for (int d = 1; d < N - 1; d = d * 2) begin
      gt = gk;
      pt = pk;
      for (int i = d; i < N - 1; i++) begin
        gk[i] = gt[i] | (pt[i] & gt[i-d]);
        pk[i] = pt[i] & pt[i-d];
      end
    end
    sum = (u ^ v) ^ {gk, 1'b0};
  end

  assign {cy, s} = sum;

endmodule

// File: rtl/add3_seq_ctrl.sv
// add3_seq_ctrl: sequencer computing a+b+c+cin over W bits, one SLICE-bit
// slice per clock, LSB slice first, with the 2-bit inter-slice carry held
// in a register between beats. Valid/ready handshake on both sides.
// Optional build macro ADD3_SEQ_SAT_EN: clamp the result to W bits of ones
// (and raise sat_o) while DONE if the sum overflows W bits.
module add3_seq_ctrl
  import add3_pkg::*;
#(
  parameter int W     = 32,
  parameter int SLICE = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  add3_seq_ctrl_if.slave bus
);

  localparam int NBEAT = beats(W, SLICE);
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  generate
    if ((SLICE <= 0) || (W < SLICE) || ((W % SLICE) != 0)) begin : g_bad_width
      $error("add3_seq_ctrl: W must be a positive multiple of SLICE");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [BW-1:0]      beat_q;
  logic [W-1:0]       a_q, b_q, c_q;
  logic [CARRY_W-1:0] carry_q;
  logic [W+1:0]       res_q;
  logic [SLICE-1:0]   s;
  logic [CARRY_W-1:0] cy;
  logic [W-1:0]       res_lo_next;
  logic               accept, last_beat;
  logic               in_ready, out_valid, busy;

  assign accept    = in_ready && bus.in_valid;
  assign last_beat = (beat_q == BW'(NBEAT - 1));

  add3_slice #(.SLICE(SLICE)) u_slice (
    .a   (a_q[SLICE-1:0]),
    .b   (b_q[SLICE-1:0]),
    .c   (c_q[SLICE-1:0]),
    .cin (carry_q),
    .s   (s),
    .cy  (cy)
  );

  // New slice sum enters the result from the top; earlier slices move down.
  assign res_lo_next = (res_q[W-1:0] >> SLICE) | (W'(s) << (W - SLICE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shift registers, carry, beat counter and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      carry_q <= '0;
      beat_q  <= '0;
      res_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a_i;
      b_q     <= bus.b_i;
      c_q     <= bus.c_i;
      carry_q <= {1'b0, bus.cin_i};
      beat_q  <= '0;
      res_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      c_q     <= c_q >> SLICE;
      carry_q <= cy;
      beat_q  <= beat_q + BW'(1);
      res_q   <= {(last_beat ? cy : res_q[W+1:W]), res_lo_next};
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy_o    = busy;

`ifdef ADD3_SEQ_SAT_EN
  logic clamp;
  assign clamp     = (state_q == DONE) && (res_q[W+1:W] != '0);
  assign bus.sum_o = clamp ? {2'b00, {W{1'b1}}} : res_q;
  assign bus.sat_o = clamp;
`else
  assign bus.sum_o = res_q;
  assign bus.sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_add3_seq_ctrl.sv
// tb_add3_seq_ctrl: directed self-checking bench for add3_seq_ctrl with
// W=32, SLICE=16. Expected sums are hand-computed constants; expectations
// for the clamped build follow ADD3_SEQ_SAT_EN.
module tb_add3_seq_ctrl;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;

  add3_seq_ctrl_if #(.W(32)) bus ();

  add3_seq_ctrl #(.W(32), .SLICE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set for a single accept edge, then drop in_valid.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic cin);
    checkOutput({tag, " in_ready before accept"}, 64'(bus.in_ready), 64'd1);
    bus.a_i      = a;
    bus.b_i      = b;
    bus.c_i      = c;
    bus.cin_i    = cin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Two beats after the accept edge, check the result and hand it off.
  task automatic runAndCheck(input string tag, input logic [33:0] expSum, input logic expSat);
    tick();
    checkOutput({tag, " out_valid after beat0"}, 64'(bus.out_valid), 64'd0);
    tick();
    checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({tag, " sum_o"}, 64'(bus.sum_o), 64'(expSum));
    checkOutput({tag, " sat_o"}, 64'(bus.sat_o), 64'(expSat));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput({tag, " out_valid after handoff"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, " in_ready after handoff"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Directed test sequence.
  initial begin
    logic [33:0] expT1Sum;
    logic        expT1Sat;
`ifdef ADD3_SEQ_SAT_EN
    expT1Sum = 34'h0_FFFF_FFFF;
    expT1Sat = 1'b1;
`else
    expT1Sum = 34'h2_FFFF_FFFE;
    expT1Sat = 1'b0;
`endif
    assertCount   = 0;
    failCount     = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus.c_i       = '0;
    bus.cin_i     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) tick();
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset sum_o", 64'(bus.sum_o), 64'd0);
    checkOutput("reset sat_o", 64'(bus.sat_o), 64'd0);
    checkOutput("reset busy_o", 64'(bus.busy_o), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] test 1: all ones plus carry-in");
    applyStimulus("t1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checkOutput("t1 busy after accept", 64'(bus.busy_o), 64'd1);
    checkOutput("t1 in_ready after accept", 64'(bus.in_ready), 64'd0);
    checkOutput("t1 out_valid at accept", 64'(bus.out_valid), 64'd0);
    runAndCheck("t1", expT1Sum, expT1Sat);

    $display("[TB] test 2: inter-slice carry of 2");
    applyStimulus("t2", 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    runAndCheck("t2", 34'h0_0002_FFFD, 1'b0);

    $display("[TB] test 3: consumer stall");
    applyStimulus("t3", 32'd1, 32'd2, 32'd3, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3 hold out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("t3 hold sum_o", 64'(bus.sum_o), 64'd6);
      checkOutput("t3 hold sat_o", 64'(bus.sat_o), 64'd0);
      checkOutput("t3 hold in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("t3 hold busy_o", 64'(bus.busy_o), 64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("t3 out_valid after release", 64'(bus.out_valid), 64'd0);
    checkOutput("t3 in_ready after release", 64'(bus.in_ready), 64'd1);
    checkOutput("t3 busy after release", 64'(bus.busy_o), 64'd0);

    $display("[TB] test 4: reset during RUN");
    applyStimulus("t4", 32'd9, 32'd9, 32'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t4 in_ready in reset", 64'(bus.in_ready), 64'd1);
    checkOutput("t4 out_valid in reset", 64'(bus.out_valid), 64'd0);
    checkOutput("t4 busy in reset", 64'(bus.busy_o), 64'd0);
    checkOutput("t4 sum_o in reset", 64'(bus.sum_o), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t4 out_valid after abort", 64'(bus.out_valid), 64'd0);
    end
    applyStimulus("t4 next", 32'd5, 32'd6, 32'd7, 1'b0);
    runAndCheck("t4 next", 34'd18, 1'b0);

    $display("[TB] test 5: back-to-back with in_valid held");
    bus.a_i       = 32'd1;
    bus.b_i       = 32'd1;
    bus.c_i       = 32'd1;
    bus.cin_i     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.a_i = 32'd2;
    bus.b_i = 32'd2;
    bus.c_i = 32'd2;
    checkOutput("t5 in_ready beat0", 64'(bus.in_ready), 64'd0);
    tick();
    checkOutput("t5 in_ready beat1", 64'(bus.in_ready), 64'd0);
    checkOutput("t5 out_valid beat1", 64'(bus.out_valid), 64'd0);
    tick();
    checkOutput("t5 first out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("t5 first sum_o", 64'(bus.sum_o), 64'd3);
    checkOutput("t5 in_ready in DONE", 64'(bus.in_ready), 64'd0);
    tick();
    checkOutput("t5 idle out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t5 idle in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    checkOutput("t5 second accepted", 64'(bus.in_ready), 64'd0);
    checkOutput("t5 second busy", 64'(bus.busy_o), 64'd1);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("t5 second out_valid beat1", 64'(bus.out_valid), 64'd0);
    tick();
    checkOutput("t5 second out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("t5 second sum_o", 64'(bus.sum_o), 64'd6);
    tick();
    bus.out_ready = 1'b0;
    checkOutput("t5 final in_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] test 6: boundary sum in clamp-aware build");
    applyStimulus("t6", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    runAndCheck("t6 overflow", expT1Sum, expT1Sat);
    applyStimulus("t6 small", 32'd1, 32'd2, 32'd3, 1'b0);
    runAndCheck("t6 small", 34'd6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
